// File: rtl/atom_bank_ctrl_if.sv
`timescale 1ns/1ps
// CPU-side bus bundle for atom_bank_ctrl: the 6502 address, RW and low data nibble go in,
// and the RomLatch/SwitchLatch/Status nibbles come back out to the RamRom decoder.
interface atom_bank_ctrl_if;
  logic [15:0] Addr;
  logic        RW;
  logic [3:0]  DataIn;
  logic [3:0]  RomLatch;
  logic [3:0]  SwitchLatch;
  logic [3:0]  Status;

  modport master (
    output Addr, RW, DataIn,
    input  RomLatch, SwitchLatch, Status
  );

  modport slave (
    input  Addr, RW, DataIn,
    output RomLatch, SwitchLatch, Status
  );
endinterface

// File: rtl/atom_bank_ctrl.sv
`timescale 1ns/1ps
// PHI2-clocked RomLatch/SwitchLatch register stage for the RamRom decoder, with a keyed unlock for SwitchLatch.
// Define BANK_STACK_EN to build the LIFO bank stack (push/pop, Overflow/Underflow, $BFFB flag clear).
module atom_bank_ctrl #(
  parameter int         STACK_DEPTH = 4,
  parameter int         UNLOCK_WIN  = 8,
  parameter logic [3:0] RESET_BANK  = 4'h0,
  parameter logic [3:0] KEY1        = 4'h5,
  parameter logic [3:0] KEY2        = 4'hA
) (
  input logic             PHI2,
  input logic             NRST,
  atom_bank_ctrl_if.slave bus
);

  if (STACK_DEPTH < 2 || STACK_DEPTH > 8 || UNLOCK_WIN < 1 || UNLOCK_WIN > 15) begin : g_param_check
    $error("atom_bank_ctrl: STACK_DEPTH must be 2..8 and UNLOCK_WIN 1..15");
  end

  localparam logic [3:0] WIN_LOAD = 4'(UNLOCK_WIN - 1);

  typedef enum logic [1:0] {
    LOCKED  = 2'd0,
    KEY1_OK = 2'd1,
    ARMED   = 2'd2
  } unlock_state_t;

  unlock_state_t state_q, state_d;
  logic [3:0]    timer_q, timer_d;
  logic [3:0]    switch_q;
  logic [3:0]    rom_q;
  logic          sw_load;
  logic          armed;

  logic wr_cycle, vec_fetch, wr_push, wr_key, wr_switch;

  assign wr_cycle  = ~bus.RW;
  assign vec_fetch = bus.RW && (bus.Addr == 16'hFFFC);
  assign wr_push   = wr_cycle && (bus.Addr == 16'hBFFF);
  assign wr_key    = wr_cycle && (bus.Addr == 16'hBFFD);
  assign wr_switch = wr_cycle && (bus.Addr == 16'hBFFE);

  // Unlock sequencer: a wrong key or an expired window drops straight back to LOCKED.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    sw_load = 1'b0;
    if (vec_fetch) begin
      state_d = LOCKED;
      timer_d = 4'h0;
    end else begin
      case (state_q)
        LOCKED: begin
          if (wr_key && (bus.DataIn == KEY1)) begin
            state_d = KEY1_OK;
            timer_d = WIN_LOAD;
          end
        end
        KEY1_OK: begin
          if (wr_key) begin
            if (bus.DataIn == KEY2) begin
              state_d = ARMED;
              timer_d = WIN_LOAD;
            end else begin
              state_d = LOCKED;
              timer_d = 4'h0;
            end
          end else if (timer_q == 4'h0) begin
            state_d = LOCKED;
          end else begin
            timer_d = timer_q - 4'd1;
          end
        end
        ARMED: begin
          if (wr_switch) begin
            sw_load = 1'b1;
            state_d = LOCKED;
            timer_d = 4'h0;
          end else if (timer_q == 4'h0) begin
            state_d = LOCKED;
          end else begin
            timer_d = timer_q - 4'd1;
          end
        end
        default: begin
          state_d = LOCKED;
          timer_d = 4'h0;
        end
      endcase
    end
  end

  always_ff @(negedge PHI2 or negedge NRST) begin
    if (!NRST) begin
      state_q  <= LOCKED;
      timer_q  <= 4'h0;
      switch_q <= 4'h0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if (sw_load) begin
        switch_q <= bus.DataIn;
      end
    end
  end

  assign armed = (state_q == ARMED);

`ifdef BANK_STACK_EN
  localparam int                 DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam logic [DEPTH_W-1:0] FULL    = DEPTH_W'(STACK_DEPTH);

  logic [3:0]         stack_q [STACK_DEPTH];
  logic [DEPTH_W-1:0] depth_q;
  logic               underflow_q, overflow_q;
  logic [3:0]         top_entry;
  logic               wr_pop, wr_clear;

  assign wr_pop   = wr_cycle && (bus.Addr == 16'hBFFC);
  assign wr_clear = wr_cycle && (bus.Addr == 16'hBFFB);

  // Entry 0 is the oldest; an empty stack pops RESET_BANK.
  always_comb begin
    top_entry = RESET_BANK;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (depth_q == DEPTH_W'(i + 1)) begin
        top_entry = stack_q[i];
      end
    end
  end

  always_ff @(negedge PHI2 or negedge NRST) begin
    if (!NRST) begin
      rom_q       <= RESET_BANK;
      depth_q     <= '0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= 4'h0;
      end
    end else if (vec_fetch) begin
      rom_q       <= RESET_BANK;
      depth_q     <= '0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (wr_push) begin
      rom_q <= bus.DataIn;
      if (depth_q == FULL) begin
        // Full: slide everything toward the bottom so the oldest bank falls off.
        for (int i = 0; i < STACK_DEPTH - 1; i++) begin
          stack_q[i] <= stack_q[i + 1];
        end
        stack_q[STACK_DEPTH - 1] <= rom_q;
        overflow_q               <= 1'b1;
      end else begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
          if (depth_q == DEPTH_W'(i)) begin
            stack_q[i] <= rom_q;
          end
        end
        depth_q <= depth_q + DEPTH_W'(1);
      end
    end else if (wr_pop) begin
      rom_q <= top_entry;
      if (depth_q == '0) begin
        underflow_q <= 1'b1;
      end else begin
        depth_q <= depth_q - DEPTH_W'(1);
      end
    end else if (wr_clear) begin
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end
  end

  assign bus.Status = {armed, underflow_q, overflow_q, (depth_q == '0)};
`else
  always_ff @(negedge PHI2 or negedge NRST) begin
    if (!NRST) begin
      rom_q <= RESET_BANK;
    end else if (vec_fetch) begin
      rom_q <= RESET_BANK;
    end else if (wr_push) begin
      rom_q <= bus.DataIn;
    end
  end

  assign bus.Status = {armed, 3'b001};
`endif

  assign bus.RomLatch    = rom_q;
  assign bus.SwitchLatch = switch_q;

endmodule

// File: tb/tb_atom_bank_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for atom_bank_ctrl: a behavioural model predicts RomLatch/SwitchLatch/Status per PHI2 cycle.
// The model follows BANK_STACK_EN the same way the design does.
module tb_atom_bank_ctrl;

  localparam int         STACK_DEPTH = 4;
  localparam int         UNLOCK_WIN  = 8;
  localparam logic [3:0] RESET_BANK  = 4'h0;
  localparam logic [3:0] KEY1        = 4'h5;
  localparam logic [3:0] KEY2        = 4'hA;

  logic PHI2;
  logic NRST;

  atom_bank_ctrl_if bus ();

  atom_bank_ctrl #(
    .STACK_DEPTH(STACK_DEPTH),
    .UNLOCK_WIN (UNLOCK_WIN),
    .RESET_BANK (RESET_BANK),
    .KEY1       (KEY1),
    .KEY2       (KEY2)
  ) dut (
    .PHI2(PHI2),
    .NRST(NRST),
    .bus (bus)
  );

  typedef enum {M_LOCKED, M_KEY1, M_ARMED} model_state_t;

  typedef struct {
    string      tag;
    logic [3:0] rom;
    logic [3:0] sw;
    logic [3:0] status;
  } exp_t;

  exp_t         expQ[$];
  int           assertCount = 0;
  int           failCount   = 0;

  logic [3:0]   mRom;
  logic [3:0]   mSw;
  model_state_t mState;
  int           mTimer;
`ifdef BANK_STACK_EN
  logic [3:0]   mStack[$];
  logic         mUnder;
  logic         mOver;
`endif

  initial begin
    PHI2 = 1'b1;
    forever #5 PHI2 = ~PHI2;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [3:0] modelStatus();
`ifdef BANK_STACK_EN
    return {mState == M_ARMED, mUnder, mOver, mStack.size() == 0};
`else
    return {mState == M_ARMED, 3'b001};
`endif
  endfunction

  task automatic modelReset();
    mRom   = RESET_BANK;
    mSw    = 4'h0;
    mState = M_LOCKED;
    mTimer = 0;
`ifdef BANK_STACK_EN
    mStack.delete();
    mUnder = 1'b0;
    mOver  = 1'b0;
`endif
  endtask

  // One PHI2 falling edge worth of behaviour for the given bus cycle.
  task automatic modelStep(input logic [15:0] addr, input logic rw, input logic [3:0] data);
    logic wr;
    wr = ~rw;
    if (rw && addr == 16'hFFFC) begin
      mRom   = RESET_BANK;
      mState = M_LOCKED;
      mTimer = 0;
`ifdef BANK_STACK_EN
      mStack.delete();
      mUnder = 1'b0;
      mOver  = 1'b0;
`endif
      return;
    end
`ifdef BANK_STACK_EN
    if (wr && addr == 16'hBFFF) begin
      if (mStack.size() == STACK_DEPTH) begin
        void'(mStack.pop_front());
        mOver = 1'b1;
      end
      mStack.push_back(mRom);
      mRom = data;
    end else if (wr && addr == 16'hBFFC) begin
      if (mStack.size() == 0) begin
        mRom   = RESET_BANK;
        mUnder = 1'b1;
      end else begin
        mRom = mStack.pop_back();
      end
    end else if (wr && addr == 16'hBFFB) begin
      mUnder = 1'b0;
      mOver  = 1'b0;
    end
`else
    if (wr && addr == 16'hBFFF) mRom = data;
`endif
    case (mState)
      M_LOCKED: begin
        if (wr && addr == 16'hBFFD && data == KEY1) begin
          mState = M_KEY1;
          mTimer = UNLOCK_WIN - 1;
        end
      end
      M_KEY1: begin
        if (wr && addr == 16'hBFFD) begin
          if (data == KEY2) begin
            mState = M_ARMED;
            mTimer = UNLOCK_WIN - 1;
          end else begin
            mState = M_LOCKED;
          end
        end else if (mTimer == 0) mState = M_LOCKED;
        else mTimer--;
      end
      M_ARMED: begin
        if (wr && addr == 16'hBFFE) begin
          mSw    = data;
          mState = M_LOCKED;
        end else if (mTimer == 0) mState = M_LOCKED;
        else mTimer--;
      end
      default: mState = M_LOCKED;
    endcase
  endtask

  task automatic pushExpected(input string tag);
    exp_t e;
    e.tag    = tag;
    e.rom    = mRom;
    e.sw     = mSw;
    e.status = modelStatus();
    expQ.push_back(e);
  endtask

  task automatic compareScoreboard();
    exp_t e;
    e = expQ.pop_front();
    checkOutput({e.tag, ".rom"},    bus.RomLatch,    e.rom);
    checkOutput({e.tag, ".sw"},     bus.SwitchLatch, e.sw);
    checkOutput({e.tag, ".status"}, bus.Status,      e.status);
  endtask

  // Drive one bus cycle mid-PHI2-high, then compare just after the falling edge.
  task automatic applyStimulus(input string tag, input logic [15:0] addr, input logic rw, input logic [3:0] data);
    @(posedge PHI2);
    bus.Addr   = addr;
    bus.RW     = rw;
    bus.DataIn = data;
    modelStep(addr, rw, data);
    pushExpected(tag);
    @(negedge PHI2);
    #1;
    compareScoreboard();
    bus.Addr = 16'h0000;
    bus.RW   = 1'b1;
  endtask

  task automatic writeOp(input string tag, input logic [15:0] addr, input logic [3:0] data);
    applyStimulus(tag, addr, 1'b0, data);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus("idle", 16'h0000, 1'b1, 4'h0);
  endtask

  // Asynchronous reset pulse placed between falling edges; outputs are checked while NRST is low.
  task automatic pulseReset(input string tag);
    @(posedge PHI2);
    #1 NRST = 1'b0;
    #1;
    modelReset();
    pushExpected(tag);
    compareScoreboard();
    #1 NRST = 1'b1;
  endtask

  task automatic randomOps(input int n);
    logic [15:0] addrTab [8];
    logic [15:0] a;
    logic        rw;
    logic [3:0]  d;
    addrTab = '{16'hBFFF, 16'hBFFC, 16'hBFFB, 16'hBFFD, 16'hBFFE, 16'hFFFC, 16'h0000, 16'hBFFD};
    for (int i = 0; i < n; i++) begin
      a  = addrTab[$urandom_range(0, 7)];
      rw = (a == 16'hFFFC) ? 1'b1 : ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       d = KEY1;
        1:       d = KEY2;
        default: d = 4'($urandom_range(0, 15));
      endcase
      applyStimulus("rand", a, rw, d);
    end
  endtask

  initial begin
    NRST       = 1'b0;
    bus.Addr   = 16'h0000;
    bus.RW     = 1'b1;
    bus.DataIn = 4'h0;
    modelReset();
    repeat (2) @(negedge PHI2);
    #1;
    pushExpected("por");
    compareScoreboard();
    @(posedge PHI2);
    #1 NRST = 1'b1;

    // Push/pop basics and underflow
    writeOp("t2_push3", 16'hBFFF, 4'h3);
    writeOp("t2_push7", 16'hBFFF, 4'h7);
    writeOp("t2_pop1",  16'hBFFC, 4'h0);
    writeOp("t2_pop2",  16'hBFFC, 4'h0);
    writeOp("t2_pop3",  16'hBFFC, 4'h0);
    writeOp("t2_clr",   16'hBFFB, 4'h0);

    // Overflow then drain past empty
    for (int i = 1; i <= 5; i++) writeOp("t3_push", 16'hBFFF, 4'(i));
    for (int i = 0; i < 5; i++)  writeOp("t3_pop",  16'hBFFC, 4'h0);
    writeOp("t3_clr", 16'hBFFB, 4'h0);

    // Unlock, immediate target write
    writeOp("t4_key1", 16'hBFFD, KEY1);
    writeOp("t4_key2", 16'hBFFD, KEY2);
    writeOp("t4_sw9",  16'hBFFE, 4'h9);
    // Target write on the last cycle of the window
    writeOp("t4b_key1", 16'hBFFD, KEY1);
    writeOp("t4b_key2", 16'hBFFD, KEY2);
    idleCycles(UNLOCK_WIN - 1);
    writeOp("t4b_sw6", 16'hBFFE, 4'h6);
    // One cycle too late
    writeOp("t4c_key1", 16'hBFFD, KEY1);
    writeOp("t4c_key2", 16'hBFFD, KEY2);
    idleCycles(UNLOCK_WIN);
    writeOp("t4c_sw3", 16'hBFFE, 4'h3);
    // Second key on the last cycle of its window
    writeOp("t4d_key1", 16'hBFFD, KEY1);
    idleCycles(UNLOCK_WIN - 1);
    writeOp("t4d_key2", 16'hBFFD, KEY2);
    writeOp("t4d_sw1",  16'hBFFE, 4'h1);
    // Second key one cycle too late
    writeOp("t4e_key1", 16'hBFFD, KEY1);
    idleCycles(UNLOCK_WIN);
    writeOp("t4e_key2", 16'hBFFD, KEY2);
    writeOp("t4e_swc",  16'hBFFE, 4'hC);

    // Wrong second key and direct target writes
    writeOp("t5_key1", 16'hBFFD, KEY1);
    writeOp("t5_bad",  16'hBFFD, 4'h3);
    writeOp("t5_sw6",  16'hBFFE, 4'h6);
    writeOp("t5_sw2",  16'hBFFE, 4'h2);

    // Vector fetch with stacked banks while armed
    writeOp("t6_push1", 16'hBFFF, 4'h1);
    writeOp("t6_pushc", 16'hBFFF, 4'hC);
    writeOp("t6_key1",  16'hBFFD, KEY1);
    writeOp("t6_key2",  16'hBFFD, KEY2);
    writeOp("t6_sw9",   16'hBFFE, 4'h9);
    writeOp("t6_key1b", 16'hBFFD, KEY1);
    writeOp("t6_key2b", 16'hBFFD, KEY2);
    applyStimulus("t6_vec", 16'hFFFC, 1'b1, 4'h0);
    writeOp("t6_sw4",   16'hBFFE, 4'h4);
    writeOp("t6_pop",   16'hBFFC, 4'h0);

    // Vector fetch between the two keys aborts the sequence
    writeOp("t7_key1", 16'hBFFD, KEY1);
    applyStimulus("t7_vec", 16'hFFFC, 1'b1, 4'h0);
    writeOp("t7_key2", 16'hBFFD, KEY2);
    writeOp("t7_swe",  16'hBFFE, 4'hE);

    // Reset while armed and with banks stacked
    writeOp("t8_pushb", 16'hBFFF, 4'hB);
    writeOp("t8_key1",  16'hBFFD, KEY1);
    writeOp("t8_key2",  16'hBFFD, KEY2);
    pulseReset("t8_rst");
    writeOp("t8_sw8",   16'hBFFE, 4'h8);
    writeOp("t8_pop",   16'hBFFC, 4'h0);

    randomOps(120);
    pulseReset("t9_rst");
    randomOps(60);

    checkOutput("sb_drain", 4'(expQ.size()), 4'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
